sdram_responder: RTL and testbench

- Synthesizable single-device SDRAM responder: the device end of the 32-bit single-word SDRAM command bus that epRISC_SDRAM drives.
- Decodes init, activate, read, write, precharge and refresh commands, keeps per-bank open-row state and returns read data at the programmed CAS latency.
- Backing store is block RAM.
- Used as the SDRAM stand-in for FPGA self-test builds and as the protocol checker in controller benches; sticky error flags report protocol violations.

---
 rtl/sdram_pkg.sv | 44 ++++
 rtl/sdram_bank_state.sv | 52 +++++
 rtl/sdram_responder.sv | 218 +++++++++++++++++++++
 tb/tb_sdram_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM device-side responder: command codes,
// error codes, mode-register fields and the top-level state enum.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_NOT_INIT     = 3'd1,
        ERR_ACT_OPEN     = 3'd2,
        ERR_CAS_CLOSED   = 3'd3,
        ERR_TRCD         = 3'd4,
        ERR_REF_OPEN     = 3'd5,
        ERR_BAD_MODE     = 3'd6,
        ERR_BUS_CONFLICT = 3'd7
    } err_e;

    typedef enum logic {
        ST_UNINIT = 1'b0,
        ST_READY  = 1'b1
    } state_e;

    localparam int MR_BL_LSB     = 0;
    localparam int MR_BL_MSB     = 2;
    localparam int MR_CL_LSB     = 4;
    localparam int MR_CL_MSB     = 6;
    localparam int AP_BIT        = 10;
    localparam int RD_PIPE_DEPTH = 3;

    // Only burst length 1 with CL 2 or 3 is supported.
    function automatic logic mode_valid(input logic [2:0] bl, input logic [2:0] cl);
        return (bl == 3'd0) && ((cl == 3'd2) || (cl == 3'd3));
    endfunction

endpackage

// File: rtl/sdram_bank_state.sv
// One SDRAM bank: open flag, open row and the ACT-to-CAS (tRCD) down-counter.
module sdram_bank_state #(
    parameter int ROW_WIDTH = 12,
    parameter int TRCD      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 act_i,
    input  logic                 close_i,
    input  logic [ROW_WIDTH-1:0] row_i,
    output logic                 open_o,
    output logic [ROW_WIDTH-1:0] row_o,
    output logic                 trcd_busy_o
);

    localparam int CNT_W = (TRCD > 2) ? $clog2(TRCD) : 1;
    localparam logic [CNT_W-1:0] TRCD_LOAD = CNT_W'(TRCD - 1);

    logic                 open_q, open_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q <= 1'b0;
            row_q  <= '0;
            cnt_q  <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        cnt_d  = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        if (act_i) begin
            open_d = 1'b1;
            row_d  = row_i;
            cnt_d  = TRCD_LOAD;
        end else if (close_i) begin
            open_d = 1'b0;
        end
    end

    assign open_o      = open_q;
    assign row_o       = row_q;
    assign trcd_busy_o = (cnt_q != '0);

endmodule

// File: rtl/sdram_responder.sv
// Device end of a single-word 32-bit SDRAM command bus: decodes commands,
// tracks per-bank rows, returns read data at CAS latency, flags protocol errors.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_WIDTH      = 12,
    parameter int COL_WIDTH      = 9,
    parameter int BANK_WIDTH     = 2,
    parameter int SDRADDR_WIDTH  = 12,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int TRCD           = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SDRADDR_WIDTH-1:0] addr_i,
    input  logic [BANK_WIDTH-1:0]    bank_addr_i,
    inout  wire  [31:0]              data_io,
    input  logic                     clock_enable_i,
    input  logic                     cs_n_i,
    input  logic                     ras_n_i,
    input  logic                     cas_n_i,
    input  logic                     we_n_i,
    input  logic [3:0]               data_mask_i,
    output logic                     mode_set_o,
    output logic [2:0]               cas_latency_o,
    output logic [15:0]              refresh_count_o,
    output logic                     err_flag_o,
    output logic [2:0]               err_code_o
);

    localparam int NBANKS = 1 << BANK_WIDTH;
    localparam int IDX_W  = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

    state_e state_q, state_d;

    logic                     cmd_valid;
    cmd_e                     cmd;
    err_e                     err_now;
    logic                     do_act, do_read, do_write, do_pre, do_ref, do_mrs;
    logic                     sel_open, sel_busy;

    logic [NBANKS-1:0]        bank_open, bank_busy, bank_act, bank_close;
    logic [ROW_WIDTH-1:0]     bank_row [NBANKS];

    logic                     mode_set_q, mode_set_d;
    logic [2:0]               cl_q, cl_d;
    logic [15:0]              ref_cnt_q, ref_cnt_d;
    logic                     err_flag_q, err_flag_d;
    err_e                     err_code_q, err_code_d;

    logic [RD_PIPE_DEPTH-1:0] vld_q, vld_d;
    logic [31:0]              mem_q [2**MEM_ADDR_WIDTH];
    logic [31:0]              rd_word_q, rd_pipe1_q, rd_pipe2_q;
    logic                     drive_en;
    logic [31:0]              drive_word;

    logic [IDX_W-1:0]         full_idx;
    logic [MEM_ADDR_WIDTH-1:0] mem_idx;
    logic                     unused_idx_bits;

    assign cmd_valid = clock_enable_i & ~cs_n_i;
    assign cmd       = cmd_e'({ras_n_i, cas_n_i, we_n_i});
    assign sel_open  = bank_open[bank_addr_i];
    assign sel_busy  = bank_busy[bank_addr_i];

    // Top FSM: state register / next state / command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_UNINIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (do_mrs) begin
            state_d = ST_READY;
        end
    end

    always_comb begin
        err_now  = ERR_NONE;
        do_act   = 1'b0;
        do_read  = 1'b0;
        do_write = 1'b0;
        do_pre   = 1'b0;
        do_ref   = 1'b0;
        do_mrs   = 1'b0;
        if (cmd_valid) begin
            case (cmd)
                CMD_ACT: begin
                    if (state_q == ST_UNINIT)  err_now = ERR_NOT_INIT;
                    else if (sel_open)         err_now = ERR_ACT_OPEN;
                    else                       do_act  = 1'b1;
                end
                CMD_READ, CMD_WRITE: begin
                    if (state_q == ST_UNINIT)  err_now = ERR_NOT_INIT;
                    else if (!sel_open)        err_now = ERR_CAS_CLOSED;
                    else if (sel_busy)         err_now = ERR_TRCD;
                    else if (cmd == CMD_WRITE && drive_en) err_now = ERR_BUS_CONFLICT;
                    else if (cmd == CMD_READ)  do_read  = 1'b1;
                    else                       do_write = 1'b1;
                end
                CMD_PRE: do_pre = 1'b1;
                CMD_REF: begin
                    if (|bank_open)            err_now = ERR_REF_OPEN;
                    else                       do_ref  = 1'b1;
                end
                CMD_MRS: begin
                    if (mode_valid(addr_i[MR_BL_MSB:MR_BL_LSB], addr_i[MR_CL_MSB:MR_CL_LSB]))
                        do_mrs  = 1'b1;
                    else
                        err_now = ERR_BAD_MODE;
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBANKS; gi++) begin : g_bank
            logic hit;
            assign hit            = (bank_addr_i == BANK_WIDTH'(gi));
            assign bank_act[gi]   = do_act & hit;
            assign bank_close[gi] = (do_pre & (addr_i[AP_BIT] | hit)) |
                                    ((do_read | do_write) & addr_i[AP_BIT] & hit);

            sdram_bank_state #(
                .ROW_WIDTH (ROW_WIDTH),
                .TRCD      (TRCD)
            ) u_bank (
                .clk         (clk),
                .rst_n       (rst_n),
                .act_i       (bank_act[gi]),
                .close_i     (bank_close[gi]),
                .row_i       (addr_i[ROW_WIDTH-1:0]),
                .open_o      (bank_open[gi]),
                .row_o       (bank_row[gi]),
                .trcd_busy_o (bank_busy[gi])
            );
        end
    endgenerate

    // Only the low bits of {bank,row,col} address the store; the rest alias.
    assign full_idx        = {bank_addr_i, bank_row[bank_addr_i], addr_i[COL_WIDTH-1:0]};
    assign mem_idx         = full_idx[MEM_ADDR_WIDTH-1:0];
    assign unused_idx_bits = ^full_idx[IDX_W-1:MEM_ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (!data_mask_i[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= data_io[8*b +: 8];
                end
            end
        end
        if (do_read) begin
            rd_word_q <= mem_q[mem_idx];
        end
    end

    always_ff @(posedge clk) begin
        rd_pipe1_q <= rd_word_q;
        rd_pipe2_q <= rd_pipe1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_set_q <= 1'b0;
            cl_q       <= '0;
            ref_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            err_code_q <= ERR_NONE;
            vld_q      <= '0;
        end else begin
            mode_set_q <= mode_set_d;
            cl_q       <= cl_d;
            ref_cnt_q  <= ref_cnt_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
            vld_q      <= vld_d;
        end
    end

    always_comb begin
        mode_set_d = mode_set_q;
        cl_d       = cl_q;
        ref_cnt_d  = ref_cnt_q;
        err_flag_d = err_flag_q;
        err_code_d = err_code_q;
        vld_d      = {vld_q[RD_PIPE_DEPTH-2:0], do_read};
        if (do_mrs) begin
            mode_set_d = 1'b1;
            cl_d       = addr_i[MR_CL_MSB:MR_CL_LSB];
        end
        if (do_ref && ref_cnt_q != 16'hFFFF) begin
            ref_cnt_d = ref_cnt_q + 16'd1;
        end
        if (err_now != ERR_NONE && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_code_d = err_now;
        end
    end

    // Read data occupies the bus for the single cycle ending at edge E+CL.
    assign drive_en   = (cl_q == 3'd3) ? vld_q[2] : vld_q[1];
    assign drive_word = (cl_q == 3'd3) ? rd_pipe2_q : rd_pipe1_q;
    assign data_io    = drive_en ? drive_word : 32'hzzzz_zzzz;

    assign mode_set_o      = mode_set_q;
    assign cas_latency_o   = cl_q;
    assign refresh_count_o = ref_cnt_q;
    assign err_flag_o      = err_flag_q;
    assign err_code_o      = err_code_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed protocol scenarios plus randomized
// command streams checked against a cycle-indexed behavioural model.
module tb_sdram_responder;

    localparam int ROW_W = 12;
    localparam int COL_W = 9;
    localparam int MA_W  = 12;
    localparam int TRCD  = 2;

    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] addr = '0;
    logic [1:0]  bank = '0;
    logic        cke = 1'b0, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [3:0]  mask = '0;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_wdata = '0;
    tri1  [31:0] data_bus;
    logic        mode_set, err_flag;
    logic [2:0]  cas_latency, err_code;
    logic [15:0] refresh_count;

    assign data_bus = tb_oe ? tb_wdata : 32'hzzzz_zzzz;

    sdram_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .addr_i          (addr),
        .bank_addr_i     (bank),
        .data_io         (data_bus),
        .clock_enable_i  (cke),
        .cs_n_i          (cs_n),
        .ras_n_i         (ras_n),
        .cas_n_i         (cas_n),
        .we_n_i          (we_n),
        .data_mask_i     (mask),
        .mode_set_o      (mode_set),
        .cas_latency_o   (cas_latency),
        .refresh_count_o (refresh_count),
        .err_flag_o      (err_flag),
        .err_code_o      (err_code)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Reference model: state as the protocol describes it, read returns keyed by edge number.
    bit          m_ready, m_mode, m_eflag;
    int          m_cl, m_ref, m_ecode;
    bit          m_open [4];
    int          m_row  [4];
    int          m_act  [4];
    logic [31:0] m_mem  [1 << MA_W];
    bit          m_known[1 << MA_W];
    logic [31:0] m_drv  [int];
    bit          m_drv_known [int];

    function automatic int mem_index(input int b, input int row, input int col);
        return ((((b << ROW_W) | row) << COL_W) | col) & ((1 << MA_W) - 1);
    endfunction

    task automatic model_reset();
        m_ready = 0; m_mode = 0; m_eflag = 0;
        m_cl = 0; m_ref = 0; m_ecode = 0;
        for (int i = 0; i < 4; i++) m_open[i] = 0;
        m_drv.delete();
        m_drv_known.delete();
    endtask

    // Apply the command currently on the pins at the upcoming edge.
    task automatic model_edge();
        int e, b, err, idx, cl_f;
        bit any_open;
        e = edge_cnt; b = int'(bank); err = 0;
        any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        if (cke && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                C_ACT: begin
                    if (!m_ready) err = 1;
                    else if (m_open[b]) err = 2;
                    else begin m_open[b] = 1; m_row[b] = int'(addr); m_act[b] = e; end
                end
                C_RD, C_WR: begin
                    if (!m_ready) err = 1;
                    else if (!m_open[b]) err = 3;
                    else if (e - m_act[b] < TRCD) err = 4;
                    else if (!we_n && m_drv.exists(e - 1)) err = 7;
                    else begin
                        idx = mem_index(b, m_row[b], int'(addr[8:0]));
                        if (we_n) begin
                            m_drv[e + m_cl - 1] = m_mem[idx];
                            m_drv_known[e + m_cl - 1] = m_known[idx];
                        end else begin
                            for (int i = 0; i < 4; i++)
                                if (!mask[i]) m_mem[idx][8*i +: 8] = tb_wdata[8*i +: 8];
                            if (mask == 4'b0000) m_known[idx] = 1;
                        end
                        if (addr[10]) m_open[b] = 0;
                    end
                end
                C_PRE: begin
                    if (addr[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
                    else m_open[b] = 0;
                end
                C_REF: begin
                    if (any_open) err = 5;
                    else if (m_ref < 65535) m_ref++;
                end
                C_MRS: begin
                    cl_f = int'(addr[6:4]);
                    if (addr[2:0] == 3'd0 && (cl_f == 2 || cl_f == 3)) begin
                        m_cl = cl_f; m_mode = 1; m_ready = 1;
                    end else err = 6;
                end
                default: ;
            endcase
        end
        if (err != 0 && !m_eflag) begin m_eflag = 1; m_ecode = err; end
    endtask

    task automatic check_outputs();
        int k;
        k = edge_cnt - 1;
        check_eq("mode_set", 32'(mode_set), 32'(m_mode));
        check_eq("cas_latency", 32'(cas_latency), 32'(m_cl));
        check_eq("refresh_count", 32'(refresh_count), 32'(m_ref));
        check_eq("err_flag", 32'(err_flag), 32'(m_eflag));
        check_eq("err_code", 32'(err_code), 32'(m_ecode));
        if (m_drv.exists(k)) begin
            if (m_drv_known[k]) check_eq("read_data", data_bus, m_drv[k]);
        end else begin
            check_eq("bus_idle", data_bus, 32'hFFFF_FFFF);
        end
    endtask

    task automatic tick(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                        input logic [3:0] m, input logic [31:0] wd,
                        input logic cke_v = 1'b1, input logic cs_n_v = 1'b0);
        {ras_n, cas_n, we_n} = c;
        bank = b; addr = a; mask = m; tb_wdata = wd;
        cke = cke_v; cs_n = cs_n_v;
        tb_oe = cke_v && !cs_n_v && (c == C_WR);
        if (cke_v && !cs_n_v && c != C_NOP)
            $display("[TB] edge %0d cmd=%03b bank=%0d addr=%h mask=%b wdata=%h",
                     edge_cnt, c, b, a, m, wd);
        model_edge();
        @(posedge clk);
        #1;
        {ras_n, cas_n, we_n} = C_NOP; cs_n = 1'b1; tb_oe = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic nop();                                   tick(C_NOP, 0, 0, 0, 0); endtask
    task automatic act(input logic [1:0] b, input logic [11:0] r); tick(C_ACT, b, r, 0, 0); endtask
    task automatic rd(input logic [1:0] b, input logic [11:0] a);  tick(C_RD, b, a, 0, 0); endtask
    task automatic wr(input logic [1:0] b, input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
        tick(C_WR, b, a, m, d);
    endtask

    // Asynchronous reset asserted between edges and released on a falling edge.
    task automatic do_reset();
        cs_n = 1'b1; tb_oe = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_eq("rst_bus_z", data_bus, 32'hFFFF_FFFF);
        check_eq("rst_mode_set", 32'(mode_set), 0);
        check_eq("rst_cas_latency", 32'(cas_latency), 0);
        check_eq("rst_refresh", 32'(refresh_count), 0);
        check_eq("rst_err", {28'd0, err_flag, err_code}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_cmd();
        int r;
        logic [1:0]  b;
        logic [11:0] a;
        r = $urandom_range(0, 99);
        b = 2'($urandom_range(0, 3));
        a = {1'b0, ($urandom_range(0, 5) == 0), 1'b0, 9'($urandom_range(0, 7))};
        if (r < 20)      act(b, 12'($urandom_range(0, 3)));
        else if (r < 45) rd(b, a);
        else if (r < 65) wr(b, a, $urandom, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom));
        else if (r < 72) tick(C_PRE, b, 12'($urandom), 0, 0);
        else if (r < 76) tick(C_REF, 0, 0, 0, 0);
        else if (r < 79) begin
            // Never change CL mid-stream: either re-program the same CL or a bad mode.
            if ($urandom_range(0, 1) == 0) tick(C_MRS, 0, 12'(m_cl << 4), 0, 0);
            else tick(C_MRS, 0, {5'($urandom), 4'($urandom), 3'($urandom_range(1, 7))}, 0, 0);
        end
        else if (r < 90) nop();
        else if (r < 95) tick(3'($urandom), b, a, 0, $urandom, 1'b0, 1'b0);
        else             tick(3'($urandom), b, a, 0, $urandom, 1'b1, 1'b1);
    endtask

    initial begin
        #2;
        do_reset();

        // Controller-style initialisation.
        tick(C_PRE, 0, 12'h400, 0, 0);
        tick(C_REF, 0, 0, 0, 0);
        tick(C_REF, 0, 0, 0, 0);
        tick(C_MRS, 0, 12'h230, 0, 0);
        check_eq("init_mode_set", 32'(mode_set), 1);
        check_eq("init_cl", 32'(cas_latency), 3);
        check_eq("init_refresh", 32'(refresh_count), 2);
        check_eq("init_err_flag", 32'(err_flag), 0);

        // Write with auto-precharge, reopen, read at CL3.
        act(1, 12'h005); nop();
        wr(1, 12'h412, 32'hDEADBEEF, 4'b0000);
        act(1, 12'h005); nop();
        rd(1, 12'h012); nop(); nop();
        check_eq("rd_deadbeef", data_bus, 32'hDEADBEEF);
        nop();
        check_eq("rd_released", data_bus, 32'hFFFF_FFFF);

        // Byte-masked write merge.
        wr(1, 12'h020, 32'hAABBCCDD, 4'b0000);
        wr(1, 12'h020, 32'h11223344, 4'b1010);
        rd(1, 12'h020); nop(); nop();
        check_eq("rd_masked_merge", data_bus, 32'hAA22CC44);
        nop();

        // READ one edge after ACT violates tRCD; bank stays open so REF is refused.
        tick(C_PRE, 0, 12'h400, 0, 0);
        act(2, 12'h007);
        rd(2, 12'h003);
        check_eq("trcd_err_code", 32'(err_code), 4);
        nop(); nop(); nop();
        tick(C_REF, 0, 0, 0, 0);
        check_eq("trcd_bank_open_ref", 32'(refresh_count), 2);

        // Reset with read data on the bus; memory survives.
        tick(C_PRE, 0, 12'h400, 0, 0);
        act(1, 12'h005); nop();
        rd(1, 12'h012); nop(); nop();
        check_eq("pre_reset_data", data_bus, 32'hDEADBEEF);
        do_reset();
        tick(C_REF, 0, 0, 0, 0);
        check_eq("post_reset_banks_closed", {31'd0, err_flag}, 0);
        check_eq("post_reset_refresh", 32'(refresh_count), 1);
        tick(C_MRS, 0, 12'h230, 0, 0);
        act(1, 12'h005); nop();
        rd(1, 12'h012); nop(); nop();
        check_eq("preserved_word", data_bus, 32'hDEADBEEF);
        nop();

        // WRITE on the edge that ends a read-data cycle is dropped.
        wr(1, 12'h030, 32'h12345678, 4'b0000);
        rd(1, 12'h030); nop(); nop();
        wr(1, 12'h030, 32'hCAFEF00D, 4'b0000);
        check_eq("conflict_err_code", 32'(err_code), 7);
        rd(1, 12'h030); nop(); nop();
        check_eq("conflict_write_dropped", data_bus, 32'h12345678);
        nop();

        // Commands before MRS; later errors do not overwrite the first code.
        do_reset();
        rd(0, 12'h000);
        check_eq("not_init_code", 32'(err_code), 1);
        tick(C_MRS, 0, 12'h230, 0, 0);
        act(0, 12'h001); nop();
        tick(C_REF, 0, 0, 0, 0);
        check_eq("first_err_kept", 32'(err_code), 1);
        check_eq("ref_open_no_count", 32'(refresh_count), 0);

        // Randomized episodes.
        for (int ep = 0; ep < 24; ep++) begin
            do_reset();
            tick(C_PRE, 0, 12'h400, 0, 0);
            tick(C_MRS, 0, 12'($urandom_range(2, 3) << 4), 0, 0);
            for (int i = 0; i < 50; i++) random_cmd();
            nop(); nop(); nop();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
